// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, transmitter FSM states and frame limits.
package uart_pkg;

   localparam logic [2:0] PAR_NONE  = 3'b000;
   localparam logic [2:0] PAR_ODD   = 3'b001;
   localparam logic [2:0] PAR_EVEN  = 3'b010;
   localparam logic [2:0] PAR_MARK  = 3'b011;
   localparam logic [2:0] PAR_SPACE = 3'b100;

   localparam int MIN_DATA_BITS     = 5;
   localparam int ABS_MAX_DATA_BITS = 9;
   // start + widest data + parity + two stop bits
   localparam int MAX_FRAME_BITS    = 1 + ABS_MAX_DATA_BITS + 1 + 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a length-masked data word; reused by the RX checker.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int LEN_W         = 4
) (
   input  logic [MAX_DATA_BITS-1:0] data,
   input  logic [LEN_W-1:0]         len,
   input  logic [2:0]               mode,
   output logic                     parity_bit,
   output logic                     parity_en
);

   logic [MAX_DATA_BITS-1:0] len_mask;
   logic                     data_xor;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
         assign len_mask[gi] = (len > LEN_W'(gi));
      end
   endgenerate

   assign data_xor = ^(data & len_mask);

   always_comb begin
      parity_bit = 1'b0;
      parity_en  = 1'b1;
      case (mode)
         PAR_ODD:   parity_bit = ~data_xor;
         PAR_EVEN:  parity_bit = data_xor;
         PAR_MARK:  parity_bit = 1'b1;
         PAR_SPACE: parity_bit = 1'b0;
         default:   parity_en  = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: latches a word and its format, then shifts start/data/parity/stop
// out LSB-first, one bit per baud_tick, with zero-gap chaining of a word queued in the last stop bit.
module uart_tx_frame_serializer
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int LEN_W         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     baud_tick,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MAX_DATA_BITS-1:0] data_in,
   input  logic [LEN_W-1:0]         data_len,
   input  logic [2:0]               parity_mode,
   input  logic                     stop_bits,
   output logic                     tx_out,
   output logic                     busy,
   output logic                     frame_done
);

   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_DATA_BITS);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BITS);

   tx_state_t                state_reg, state_next;
   logic [MAX_DATA_BITS-1:0] data_reg, data_next;
   logic [MAX_DATA_BITS-1:0] shift_reg, shift_next;
   logic [LEN_W-1:0]         len_reg, len_next;
   logic [LEN_W-1:0]         bit_cnt_reg, bit_cnt_next;
   logic [2:0]               mode_reg, mode_next;
   logic                     stop2_reg, stop2_next;
   logic                     stop_last_reg, stop_last_next;
   logic                     pending_reg, pending_next;
   logic                     tx_reg, tx_next;
   logic                     busy_reg, busy_next;
   logic                     done_reg, done_next;

   logic [LEN_W-1:0]         len_clamped;
   logic                     final_stop;
   logic                     accept;
   logic                     parity_bit;
   logic                     parity_en;

   assign len_clamped = (data_len < MIN_LEN) ? MIN_LEN :
                        (data_len > MAX_LEN) ? MAX_LEN : data_len;

   // A new word may be taken while idle, or during the last stop bit if nothing is queued yet.
   assign final_stop = (state_reg == ST_STOP) && stop_last_reg;
   assign in_ready   = rst && ((state_reg == ST_IDLE) || (final_stop && !pending_reg));
   assign accept     = in_valid && in_ready;

   uart_parity_gen #(
      .MAX_DATA_BITS (MAX_DATA_BITS),
      .LEN_W         (LEN_W)
   ) u_parity (
      .data       (data_reg),
      .len        (len_reg),
      .mode       (mode_reg),
      .parity_bit (parity_bit),
      .parity_en  (parity_en)
   );

   always_comb begin
      state_next     = state_reg;
      data_next      = data_reg;
      shift_next     = shift_reg;
      len_next       = len_reg;
      bit_cnt_next   = bit_cnt_reg;
      mode_next      = mode_reg;
      stop2_next     = stop2_reg;
      stop_last_next = stop_last_reg;
      pending_next   = pending_reg;
      tx_next        = tx_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;

      // Config of the running frame is no longer needed once accept is possible.
      if (accept) begin
         data_next  = data_in;
         len_next   = len_clamped;
         mode_next  = parity_mode;
         stop2_next = stop_bits;
      end

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_ARMED;
               busy_next  = 1'b1;
            end
         end
         ST_ARMED: begin
            if (baud_tick) begin
               state_next = ST_START;
               tx_next    = 1'b0;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               state_next   = ST_DATA;
               tx_next      = data_reg[0];
               shift_next   = data_reg >> 1;
               bit_cnt_next = '0;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt_reg == len_reg - LEN_W'(1)) begin
                  if (parity_en) begin
                     state_next = ST_PARITY;
                     tx_next    = parity_bit;
                  end else begin
                     state_next     = ST_STOP;
                     tx_next        = 1'b1;
                     stop_last_next = ~stop2_reg;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + LEN_W'(1);
                  tx_next      = shift_reg[0];
                  shift_next   = shift_reg >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) begin
               state_next     = ST_STOP;
               tx_next        = 1'b1;
               stop_last_next = ~stop2_reg;
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               if (!stop_last_reg) begin
                  stop_last_next = 1'b1;
               end else begin
                  done_next = 1'b1;
                  if (pending_reg) begin
                     state_next   = ST_START;
                     tx_next      = 1'b0;
                     pending_next = 1'b0;
                  end else if (accept) begin
                     state_next = ST_ARMED;
                  end else begin
                     state_next = ST_IDLE;
                     busy_next  = 1'b0;
                  end
               end
            end else if (accept) begin
               pending_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         data_reg      <= '0;
         shift_reg     <= '0;
         len_reg       <= '0;
         bit_cnt_reg   <= '0;
         mode_reg      <= '0;
         stop2_reg     <= 1'b0;
         stop_last_reg <= 1'b0;
         pending_reg   <= 1'b0;
         tx_reg        <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         data_reg      <= data_next;
         shift_reg     <= shift_next;
         len_reg       <= len_next;
         bit_cnt_reg   <= bit_cnt_next;
         mode_reg      <= mode_next;
         stop2_reg     <= stop2_next;
         stop_last_reg <= stop_last_next;
         pending_reg   <= pending_next;
         tx_reg        <= tx_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign tx_out     = tx_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: hand-built frames compared bit by bit on tx_out.
module tb_uart_tx_frame_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       baud_tick = 1'b0;
   logic       in_valid = 1'b0;
   logic [8:0] data_in = '0;
   logic [3:0] data_len = '0;
   logic [2:0] parity_mode = '0;
   logic       stop_bits = 1'b0;
   logic       in_ready;
   logic       tx_out;
   logic       busy;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   logic [12:0] f_a, f_b;

   always #5 clk = ~clk;

   uart_tx_frame_serializer #(
      .MAX_DATA_BITS (9),
      .LEN_W         (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_in     (data_in),
      .data_len    (data_len),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .tx_out      (tx_out),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bit period of 16 clocks; returns just after the negedge following the tick edge.
   task automatic tick();
      repeat (15) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
   endtask

   task automatic send(input logic [8:0] d, input logic [3:0] len, input logic [2:0] mode,
                       input logic sb, input logic with_tick, input string tag);
      int n;
      data_in     = d;
      data_len    = len;
      parity_mode = mode;
      stop_bits   = sb;
      in_valid    = 1'b1;
      baud_tick   = with_tick;
      n = 0;
      while (in_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid    = 1'b0;
      baud_tick   = 1'b0;
      data_in     = 9'h1AB;
      data_len    = 4'd0;
      parity_mode = 3'b011;
      stop_bits   = ~sb;
   endtask

   task automatic run_bits(input logic [12:0] frame, input int first, input int nbits, input string tag);
      for (int i = first; i < nbits; i++) begin
         tick();
         chk($sformatf("%s_bit%0d", tag, i), tx_out, frame[i]);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1);
         chk($sformatf("%s_nodone%0d", tag, i), frame_done, 0);
      end
   endtask

   task automatic check_end(input logic exp_tx, input logic exp_busy, input string tag);
      chk({tag, "_done"}, frame_done, 1);
      chk({tag, "_end_tx"}, tx_out, exp_tx);
      chk({tag, "_end_busy"}, busy, exp_busy);
      @(negedge clk);
      chk({tag, "_done_pulse"}, frame_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", tx_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ready", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", in_ready, 1);

      // 8N1 0x55
      send(9'h055, 4'd8, 3'b000, 1'b0, 1'b0, "t1");
      chk("t1_armed_tx", tx_out, 1);
      chk("t1_armed_busy", busy, 1);
      chk("t1_armed_ready", in_ready, 0);
      f_a = {3'b0, 1'b1, 8'h55, 1'b0};
      run_bits(f_a, 0, 10, "t1");
      tick();
      check_end(1'b1, 1'b0, "t1");
      chk("t1_idle_ready", in_ready, 1);

      // 7E2 0x41: two ones -> parity 0
      send(9'h041, 4'd7, 3'b010, 1'b1, 1'b0, "t2");
      f_a = {2'b0, 2'b11, 1'b0, 7'h41, 1'b0};
      run_bits(f_a, 0, 11, "t2");
      tick();
      check_end(1'b1, 1'b0, "t2");

      // 9O1 0x1FF with data_len above max (clamped to 9): nine ones -> parity 0
      send(9'h1FF, 4'd15, 3'b001, 1'b0, 1'b0, "t3");
      f_a = {1'b0, 1'b1, 1'b0, 9'h1FF, 1'b0};
      run_bits(f_a, 0, 12, "t3");
      tick();
      check_end(1'b1, 1'b0, "t3");

      // 5M1 0x00 -> mark parity 1
      send(9'h000, 4'd5, 3'b011, 1'b0, 1'b0, "t4");
      f_a = {5'b0, 1'b1, 1'b1, 5'h00, 1'b0};
      run_bits(f_a, 0, 8, "t4");
      tick();
      check_end(1'b1, 1'b0, "t4");

      // data_len=3 clamps to 5: low bits 01010, even parity 0 (upper bits ignored)
      send(9'h0EA, 4'd3, 3'b010, 1'b0, 1'b0, "t5");
      f_a = {5'b0, 1'b1, 1'b0, 5'h0A, 1'b0};
      run_bits(f_a, 0, 8, "t5");
      tick();
      check_end(1'b1, 1'b0, "t5");

      // 8O1 0x03: two ones -> odd parity 1
      send(9'h003, 4'd8, 3'b001, 1'b0, 1'b0, "t6");
      f_a = {2'b0, 1'b1, 1'b1, 8'h03, 1'b0};
      run_bits(f_a, 0, 11, "t6");
      tick();
      check_end(1'b1, 1'b0, "t6");

      // back-to-back: 0xA3 queued during the final stop bit of 0x55
      send(9'h055, 4'd8, 3'b000, 1'b0, 1'b0, "t7a");
      f_a = {3'b0, 1'b1, 8'h55, 1'b0};
      f_b = {3'b0, 1'b1, 8'hA3, 1'b0};
      run_bits(f_a, 0, 10, "t7a");
      send(9'h0A3, 4'd8, 3'b000, 1'b0, 1'b0, "t7b");
      chk("t7_pending_ready", in_ready, 0);
      chk("t7_pending_tx", tx_out, 1);
      tick();
      check_end(1'b0, 1'b1, "t7a");
      run_bits(f_b, 1, 10, "t7b");
      tick();
      check_end(1'b1, 1'b0, "t7b");

      // accept coincident with a tick in IDLE: start bit waits for the next tick
      send(9'h015, 4'd5, 3'b000, 1'b0, 1'b1, "t8");
      chk("t8_armed_tx", tx_out, 1);
      chk("t8_armed_busy", busy, 1);
      repeat (5) @(negedge clk);
      chk("t8_hold_tx", tx_out, 1);
      f_a = {6'b0, 1'b1, 5'h15, 1'b0};
      run_bits(f_a, 0, 7, "t8");
      // accept coincident with the terminating tick: one idle bit period, then 6N2 0x2C
      send(9'h02C, 4'd6, 3'b000, 1'b1, 1'b1, "t9");
      check_end(1'b1, 1'b1, "t8");
      f_b = {4'b0, 2'b11, 6'h2C, 1'b0};
      run_bits(f_b, 0, 9, "t9");
      tick();
      check_end(1'b1, 1'b0, "t9");

      // reset during data bit 4 of 0x0F, then a clean retransmission
      send(9'h00F, 4'd8, 3'b000, 1'b0, 1'b0, "t10");
      f_a = {3'b0, 1'b1, 8'h0F, 1'b0};
      run_bits(f_a, 0, 6, "t10");
      #2 rst = 1'b0;
      #1;
      chk("t10_rst_tx", tx_out, 1);
      chk("t10_rst_busy", busy, 0);
      chk("t10_rst_ready", in_ready, 0);
      chk("t10_rst_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t10_post_ready", in_ready, 1);
      chk("t10_post_tx", tx_out, 1);
      send(9'h00F, 4'd8, 3'b000, 1'b0, 1'b0, "t11");
      run_bits(f_a, 0, 10, "t11");
      tick();
      check_end(1'b1, 1'b0, "t11");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
